// File: rtl/soc_design_pio_fader.sv
// soc_design_pio_fader
//   Sits between the PIO out_port and the board LEDs. Each ctrl bit picks a
//   target (on/off) for one LED; the LED brightness ramps one level per
//   prescaler tick toward that target and is driven by a shared PWM counter.
//
//   Parameters
//     PRESCALE : clock cycles per fade step (2..2^24)
//     LEVEL_W  : brightness level width (2..8); MAX = 2^LEVEL_W-1 = PWM period
//
//   Ports
//     clk     in   system clock
//     reset   in   synchronous, active-high reset
//     ctrl_in in 8 per-LED target (1 = on, 0 = off), registered before use
//     freeze  in   holds prescaler and all levels; PWM keeps running
//     led_out out 8 registered PWM drive
//     busy    out  registered; any LED fading or settled opposite to its bit
//
//   Build option
//     PIO_FADER_BREATHE_EN : when defined, an LED whose bit is 1 breathes
//     continuously (MAX -> 0 -> MAX ...) instead of resting at ON.

// Per-LED fade state machine, level register and PWM output flop.
module soc_design_pio_fader_lane #(
  parameter int LEVEL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_i,
  input  logic               ctrl_i,
  input  logic [LEVEL_W-1:0] pwm_i,
  output logic               led_o,
  output logic               busy_o
);
`ifdef PIO_FADER_BREATHE_EN
  localparam bit BREATHE = 1'b1;
`else
  localparam bit BREATHE = 1'b0;
`endif

  localparam logic [LEVEL_W-1:0] MAX = {LEVEL_W{1'b1}};

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_RISE = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_FALL = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               led_q;
  logic               up;

  // Mid-fade direction: normally follows the bit. When breathing, a set bit
  // keeps going the way it was going, so FALLING continues down to 0.
  assign up = ctrl_i && (!BREATHE || state_q == S_RISE);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (tick_i) begin
      case (state_q)
        S_OFF: begin
          if (ctrl_i) begin
            state_d = S_RISE;
            level_d = LEVEL_W'(1);
          end
        end
        S_ON: begin
          if (!ctrl_i || BREATHE) begin
            state_d = S_FALL;
            level_d = MAX - LEVEL_W'(1);
          end
        end
        default: begin
          if (up) begin
            level_d = level_q + LEVEL_W'(1);
            state_d = (level_q == MAX - LEVEL_W'(1)) ? S_ON : S_RISE;
          end else if (level_q <= LEVEL_W'(1)) begin
            // Bottom of a fade. A breathing LED bounces back up; level 0 in
            // RISING (left by a bounce) also lands here without wrapping.
            level_d = '0;
            state_d = (BREATHE && ctrl_i) ? S_RISE : S_OFF;
          end else begin
            level_d = level_q - LEVEL_W'(1);
            state_d = S_FALL;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_OFF;
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      led_q   <= (pwm_i < level_q);
    end
  end

  assign led_o  = led_q;
  assign busy_o = (state_q == S_RISE) || (state_q == S_FALL) ||
                  (state_q == S_OFF && ctrl_i) || (state_q == S_ON && !ctrl_i) ||
                  (BREATHE && ctrl_i);
endmodule

module soc_design_pio_fader #(
  parameter int PRESCALE = 50000,
  parameter int LEVEL_W  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ctrl_in,
  input  logic       freeze,
  output logic [7:0] led_out,
  output logic       busy
);
  localparam int NUM_LANES = 8;
  localparam int PRE_W     = $clog2(PRESCALE);

  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [LEVEL_W-1:0] PWM_LAST = LEVEL_W'((1 << LEVEL_W) - 2);

  logic [NUM_LANES-1:0] ctrl_q;
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic [LEVEL_W-1:0]   pwm_q, pwm_d;
  logic                 busy_q;
  logic                 tick;
  logic [NUM_LANES-1:0] lane_busy;

  assign tick = (pre_q == PRE_LAST) && !freeze;

  always_comb begin
    pre_d = pre_q;
    if (!freeze) pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
    pwm_d = (pwm_q == PWM_LAST) ? '0 : pwm_q + LEVEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
      pre_q  <= '0;
      pwm_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_in;
      pre_q  <= pre_d;
      pwm_q  <= pwm_d;
      busy_q <= |lane_busy;
    end
  end

  soc_design_pio_fader_lane #(.LEVEL_W(LEVEL_W)) u_lane [NUM_LANES-1:0] (
    .clk    (clk),
    .reset  (reset),
    .tick_i (tick),
    .ctrl_i (ctrl_q),
    .pwm_i  (pwm_q),
    .led_o  (led_out),
    .busy_o (lane_busy)
  );

  assign busy = busy_q;
endmodule

// File: tb/tb_soc_design_pio_fader.sv
// Bench for soc_design_pio_fader with PRESCALE=4, LEVEL_W=2 (MAX=3).
// A level-per-LED model predicts led_out/busy every cycle; directed phases
// pin the model with hand-derived duty and busy values.
module tb_soc_design_pio_fader;
  localparam int P   = 4;
  localparam int LW  = 2;
  localparam int MAX = 3;

  logic       clk = 1'b0;
  logic       reset, freeze, busy;
  logic [7:0] ctrl_in, led_out;

  soc_design_pio_fader #(.PRESCALE(P), .LEVEL_W(LW)) dut (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .freeze(freeze),
    .led_out(led_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int         m_lvl[8];
  bit         m_dn[8];
  bit         m_off[8];
  int         m_pre, m_pwm, m_ticks;
  logic [7:0] m_ctrl, m_led;
  logic       m_busy;

  always @(posedge clk) begin : model
    logic [7:0] led_n;
    logic       busy_n;
    bit         tick;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin m_lvl[i] = 0; m_dn[i] = 0; m_off[i] = 1; end
      m_pre = 0; m_pwm = 0; m_ctrl = '0; m_led = '0; m_busy = 1'b0;
    end else begin
      tick   = (m_pre == P - 1) && !freeze;
      busy_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
        led_n[i] = (m_pwm < m_lvl[i]);
`ifdef PIO_FADER_BREATHE_EN
        busy_n |= m_ctrl[i] || (m_lvl[i] != 0) || !m_off[i];
        if (tick) begin
          if (m_ctrl[i]) begin
            m_off[i] = 0;
            if (m_lvl[i] == 0) begin m_lvl[i] = 1; m_dn[i] = 0; end
            else if (m_lvl[i] == MAX || m_dn[i]) begin
              m_lvl[i]--; m_dn[i] = (m_lvl[i] != 0);
            end else m_lvl[i]++;
          end else begin
            if (m_lvl[i] > 0) m_lvl[i]--;
            m_dn[i] = 1;
            if (m_lvl[i] == 0) m_off[i] = 1;
          end
        end
`else
        // Without breathing the level simply walks toward the bit's target.
        busy_n |= (m_lvl[i] != (m_ctrl[i] ? MAX : 0));
        if (tick) begin
          if (m_ctrl[i] && m_lvl[i] < MAX) m_lvl[i]++;
          else if (!m_ctrl[i] && m_lvl[i] > 0) m_lvl[i]--;
        end
`endif
      end
      if (tick) m_ticks++;
      if (!freeze) m_pre = (m_pre == P - 1) ? 0 : m_pre + 1;
      m_pwm  = (m_pwm == MAX - 1) ? 0 : m_pwm + 1;
      m_led  = led_n;
      m_busy = busy_n;
      m_ctrl = ctrl_in;
    end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // One cycle: move to the falling edge and compare the DUT with the model.
  task automatic cyc();
    @(negedge clk);
    if (chk_en) begin
      n_chk++;
      if (led_out !== m_led || busy !== m_busy) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: led_out=%h busy=%b, expected led_out=%h busy=%b",
                 $time, led_out, busy, m_led, m_busy);
      end
    end
  endtask

  task automatic expect_eq(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Ones per bit over one full PWM period (3 cycles) equals the level.
  task automatic duty3(output logic [7:0][1:0] cnt);
    cnt = '0;
    repeat (3) begin
      cyc();
      for (int b = 0; b < 8; b++) cnt[b] = cnt[b] + 2'(led_out[b]);
    end
  endtask

  task automatic wait_ticks(input int tgt);
    int g = 0;
    while (m_ticks < tgt && g < 100) begin cyc(); g++; end
    if (m_ticks < tgt) begin
      n_chk++; n_fail++;
      $display("FAIL tick_wait: ticks=%0d, expected %0d within 100 cycles", m_ticks, tgt);
    end
  endtask

  logic [7:0][1:0] d;
  int              t0;
  bit              s[15];
  int              mx, w;

  initial begin
    reset = 1'b1; ctrl_in = 8'hFF; freeze = 1'b0;
    cyc();
    chk_en = 1;
    expect_eq("reset led c1", int'(led_out), 0);
    expect_eq("reset busy c1", int'(busy), 0);
    cyc();
    expect_eq("reset led c2", int'(led_out), 0);
    expect_eq("reset busy c2", int'(busy), 0);
    reset = 1'b0;
    cyc();
    expect_eq("post-reset led", int'(led_out), 0);
    expect_eq("post-reset busy", int'(busy), 0);
    ctrl_in = 8'h00;
    repeat (6) cyc();

`ifndef PIO_FADER_BREATHE_EN
    // Fade up LED 0.
    ctrl_in = 8'h01;
    cyc();
    t0 = m_ticks;
    expect_eq("fade up busy 1 cycle", int'(busy), 0);
    cyc();
    expect_eq("fade up busy 2 cycles", int'(busy), 1);
    for (int k = 1; k <= 3; k++) begin
      wait_ticks(t0 + k);
      duty3(d);
      expect_eq($sformatf("fade up duty step %0d", k), int'(d[0]), k);
      expect_eq($sformatf("fade up idle bits step %0d", k), int'(d[7]), 0);
    end
    expect_eq("fade up busy settled", int'(busy), 0);
    expect_eq("fade up led", int'(led_out), 8'h01);

    // Fade down all eight from ON.
    ctrl_in = 8'hFF;
    repeat (20) cyc();
    expect_eq("all on busy", int'(busy), 0);
    expect_eq("all on led", int'(led_out), 8'hFF);
    ctrl_in = 8'h00;
    cyc();
    t0 = m_ticks;
    for (int k = 1; k <= 3; k++) begin
      wait_ticks(t0 + k);
      duty3(d);
      expect_eq($sformatf("fade down bit0 step %0d", k), int'(d[0]), 3 - k);
      expect_eq($sformatf("fade down bit7 step %0d", k), int'(d[7]), 3 - k);
    end
    repeat (6) cyc();
    expect_eq("fade down led", int'(led_out), 0);
    expect_eq("fade down busy", int'(busy), 0);

    // Reversal after one step: level must fall back without reaching 2.
    ctrl_in = 8'h01;
    cyc();
    t0 = m_ticks;
    wait_ticks(t0 + 1);
    ctrl_in = 8'h00;
    for (int i = 0; i < 15; i++) begin cyc(); s[i] = led_out[0]; end
    mx = 0;
    for (int i = 0; i + 2 < 15; i++) begin
      w = int'(s[i]) + int'(s[i+1]) + int'(s[i+2]);
      if (w > mx) mx = w;
    end
    expect_eq("reversal first period", int'(s[0]) + int'(s[1]) + int'(s[2]), 1);
    expect_eq("reversal peak duty", mx, 1);
    expect_eq("reversal end duty", int'(s[12]) + int'(s[13]) + int'(s[14]), 0);
    expect_eq("reversal busy", int'(busy), 0);

    // Freeze at level 1 for 20 cycles, then resume.
    ctrl_in = 8'h01;
    cyc();
    t0 = m_ticks;
    wait_ticks(t0 + 1);
    freeze = 1'b1;
    for (int k = 0; k < 6; k++) begin
      duty3(d);
      expect_eq($sformatf("freeze hold %0d", k), int'(d[0]), 1);
    end
    repeat (2) cyc();
    freeze = 1'b0;
    repeat (4) cyc();
    duty3(d);
    expect_eq("freeze resume", int'(d[0]), 2);
    ctrl_in = 8'h00;
    repeat (16) cyc();
`endif

    // Randomised traffic against the model.
    repeat (1500) begin
      if ($urandom_range(0, 11) == 0) ctrl_in = 8'($urandom);
      if ($urandom_range(0, 15) == 0) freeze = ~freeze;
      reset = ($urandom_range(0, 249) == 0);
      cyc();
    end
    reset = 1'b0; freeze = 1'b0;
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/soc_design_pio_fader.md
# soc_design_pio_fader

Downstream consumer of the 8-bit PIO output register, placed between the PIO's `out_port` and the board LED pins. Each control bit selects a target state for one LED. The block ramps that LED's brightness toward full-on or full-off one level per prescaler tick and drives the pin with a shared PWM counter. Software sees smooth fades while writing only a single byte.

## Interface
- `PRESCALE`, default 50000: clock cycles per fade step; legal range 2..2^24.
- `LEVEL_W`, default 4: brightness level width. `MAX` = 2^LEVEL_W − 1, which is also the PWM period in cycles. Legal range 2..8.

- `clk`  in  1: system clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `ctrl_in`  in  8: connects to PIO `out_port`. Bit i = 1 selects LED i on; 0 selects off.
- `freeze`  in  1: while high, the prescaler and all fade levels hold. PWM keeps running.
- `led_out`  out  8: PWM-modulated LED drive, registered.
- `busy`  out  1: registered; high while any LED is not in a settled state.

## Operation
- **Input stage:** `ctrl_in` is registered into `ctrl_q` every cycle. All decisions use `ctrl_q`.
- **Prescaler:**
  - Counts 0..PRESCALE−1 and wraps.
  - `tick` is high for the one cycle where the count equals PRESCALE−1 and `freeze` is low.
  - While `freeze` is high the count holds.
- **PWM counter:**
  - `pwm_cnt` counts 0..MAX−1 and wraps. It is free-running and not affected by `freeze`.
  - `led_out[i] <= (pwm_cnt < level[i])`.
  - Level 0 means the output is constantly 0. Level MAX means it is constantly 1.
- **Per-LED state machine:** states are OFF, RISING, ON, FALLING. It changes only on `tick`.
  - OFF (level 0): if `ctrl_q[i]`=1, go to RISING and set level to 1.
  - RISING: if `ctrl_q[i]`=1, increment level. When it reaches MAX, go to ON. If `ctrl_q[i]`=0, go to FALLING and decrement level; a level of 0 goes to OFF.
  - ON (level MAX): if `ctrl_q[i]`=0, go to FALLING and set level to MAX−1.
  - FALLING: if `ctrl_q[i]`=0, decrement level. When it reaches 0, go to OFF. If `ctrl_q[i]`=1, go to RISING and increment level.
  - A direction reversal mid-fade continues from the current level. There is no jump.
- **Level arithmetic:**
  - Level is LEVEL_W bits unsigned and never wraps. It saturates at 0 and MAX because of the state transitions.
  - Only one ±1 step is taken per tick.
- **busy:** high when any LED is in RISING or FALLING, or when the settled state disagrees with `ctrl_q` (OFF with bit=1, or ON with bit=0).
- All eight LEDs step on the same tick, independently of each other.

## Timing
- **Reset values:**
  - `led_out`=0, `busy`=0.
  - All levels are 0 and all states are OFF.
  - Prescaler=0, `pwm_cnt`=0, `ctrl_q`=0.
- **Reset mid-fade:** at the next edge all levels go to 0 and `led_out` goes to 0. No fade-out occurs.
- **Control latency:**
  - 1 cycle from `ctrl_in` to `ctrl_q`.
  - `busy` rises 1 cycle after `ctrl_q` changes.
  - The first level step happens on the first tick at or after `ctrl_q` updates.
- **Full fade time:** MAX ticks = MAX·PRESCALE cycles, when `freeze` stays low.
- **Level to output:** `led_out` reflects a new level starting from the cycle after the level register updates.
- **Freeze and ctrl change together:** `ctrl_q` still updates immediately. The step is taken on the first tick after `freeze` falls.
- **Tick at the same edge as a ctrl change:** the tick uses the old `ctrl_q`.

## Configuration
- `PIO_FADER_BREATHE_EN`:
  - **Defined:** an LED whose bit is 1 breathes continuously.
    - ON goes to FALLING on the next tick.
    - FALLING at level 0 goes to RISING, not OFF, while the bit is 1.
    - `busy` stays high while any bit is 1.
    - Clearing the bit fades the LED to OFF from its current level.
  - **Not defined:** ON is stable while the bit is 1, exactly as described in Operation.

## Test plan
Bench uses PRESCALE=4, LEVEL_W=2, so MAX=3 and the PWM period is 3.
- **Reset:** assert `reset` for 2 cycles with `ctrl_in`=8'hFF → `led_out`=8'h00 and `busy`=0 on every cycle during reset and the cycle after.
- **Fade up:**
  - Stimulus: write `ctrl_in`=8'h01.
  - `busy`=1 after 2 cycles.
  - `led_out[0]` duty goes 1/3, then 2/3, then 3/3 over 3 ticks (12 cycles).
  - `busy`=0 after reaching ON; `led_out[7:1]` stays 0.
- **Fade down:** from all-ON (8'hFF settled), write 8'h00 → every bit steps 2/3, 1/3, 0, then stays 0 with `busy`=0.
- **Reversal:** write 8'h01, wait 1 tick (level 1), then write 8'h00 → level returns to 0 on the next tick, never reaching 2.
- **Freeze:** mid-fade at level 1, hold `freeze`=1 for 20 cycles → level stays 1 and the duty stays 1/3. The fade resumes within 4 cycles after release.
- **Breathe (`PIO_FADER_BREATHE_EN`):** `ctrl_in`=8'h80 → level 7 cycles 1, 2, 3, 2, 1, 0, 1… per tick. Clearing the bit at level 2 gives 1, then 0, then OFF.
